// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES types and constants for the plaintext input buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int AES_BLK_BYTES = 16;
  localparam int AES_NB        = 4;

  // AES state matrix, indexed [row][col], one byte per cell
  typedef logic [AES_NB-1:0][AES_NB-1:0][7:0] aes_state_t;

endpackage

`default_nettype wire

// File: rtl/aes_blk_fifo.sv
// ============================================================================
// Module      : aes_blk_fifo
// Description : FIFO of complete AES state blocks with occupancy level.
//               Push is dropped when full, pop is dropped when empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_blk_fifo #(
  parameter int BUF_SIZE = 4,
  parameter int NO_ROWS  = 4,
  parameter int NO_COLS  = 4
) (
  input  logic                                  aes_clk,
  input  logic                                  resetn,
  input  logic                                  push,
  input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]  push_blk,
  input  logic                                  pop,
  output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]  head_blk,
  output logic [$clog2(BUF_SIZE+1)-1:0]         level
);

  localparam int PTR_W = $clog2(BUF_SIZE);
  localparam int LVL_W = $clog2(BUF_SIZE+1);

  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] mem [BUF_SIZE];
  logic [PTR_W-1:0]                     wr_ptr;
  logic [PTR_W-1:0]                     rd_ptr;
  logic [LVL_W-1:0]                     count;
  logic                                 push_ok;
  logic                                 pop_ok;

  assign push_ok  = push && (count != LVL_W'(BUF_SIZE));
  assign pop_ok   = pop && (count != '0);
  assign head_blk = mem[rd_ptr];
  assign level    = count;

  // Block storage; cleared on reset so nothing stale is ever presented
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BUF_SIZE; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= push_blk;
    end
  end

  // Read/write pointers wrap naturally since BUF_SIZE is a power of two
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: unchanged when push and pop coincide
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/aes_encryptor_ip_buffer.sv
// ============================================================================
// Module      : aes_encryptor_ip_buffer
// Description : Assembles a plaintext byte stream into column-major AES state
//               blocks and queues complete blocks for the AES core.
//               Optional macro AES_IP_BUF_PAD_EN: in_last on a partial block
//               zero-pads the remainder and pushes it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_encryptor_ip_buffer
  import aes_pkg::*;
#(
  parameter int BUF_SIZE = 4,
  parameter int NO_ROWS  = AES_NB,
  parameter int NO_COLS  = AES_NB
) (
  input  logic                                  aes_clk,
  input  logic                                  resetn,
  input  logic [7:0]                            in_byte,
  input  logic                                  in_byte_vld,
  output logic                                  in_byte_rdy,
  input  logic                                  in_last,
  output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]  plain_txt,
  output logic                                  plain_txt_vld,
  input  logic                                  plain_txt_rdy,
  output logic [$clog2(BUF_SIZE+1)-1:0]         buf_level
);

  localparam int BLK_BYTES = NO_ROWS * NO_COLS;
  localparam int CNT_W     = $clog2(BLK_BYTES);
  localparam int LVL_W     = $clog2(BUF_SIZE+1);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(BLK_BYTES - 1);

`ifdef AES_IP_BUF_PAD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, PAD = 2'd2} fsm_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1} fsm_t;
`endif

  fsm_t                                 state;
  fsm_t                                 next_state;
  logic [CNT_W-1:0]                     byte_cnt;
  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] assembly;
  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] asm_next;
  logic                                 up;
  logic                                 accept;
  logic                                 wr_en;
  logic [7:0]                           wr_byte;
  logic                                 push;
  logic                                 full;
  logic                                 in_pad;

  assign full   = (buf_level == LVL_W'(BUF_SIZE));
  assign accept = in_byte_vld && in_byte_rdy;

`ifdef AES_IP_BUF_PAD_EN
  assign in_pad = (state == PAD);
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign in_pad         = 1'b0;
`endif

  // Stall only when the completing byte would find the FIFO full
  assign in_byte_rdy   = up && !in_pad && !((byte_cnt == LAST_POS) && full);
  assign plain_txt_vld = (buf_level != '0);

  // Ready enable rises on the first edge after reset release
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) up <= 1'b0;
    else         up <= 1'b1;
  end

  // FSM state register
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Next state, byte write and block push decisions
  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    wr_byte    = in_byte;
    push       = 1'b0;
    case (state)
      IDLE, FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (byte_cnt == LAST_POS) begin
            push       = 1'b1;
            next_state = IDLE;
          end
`ifdef AES_IP_BUF_PAD_EN
          else if (in_last) begin
            next_state = PAD;
          end
`endif
          else begin
            next_state = FILL;
          end
        end
      end
`ifdef AES_IP_BUF_PAD_EN
      PAD: begin
        // Zero-fill one position per cycle; the final write waits for room
        if ((byte_cnt != LAST_POS) || !full) begin
          wr_en   = 1'b1;
          wr_byte = 8'h00;
          if (byte_cnt == LAST_POS) begin
            push       = 1'b1;
            next_state = IDLE;
          end
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Column-major placement: byte k lands in row k%NO_ROWS, column k/NO_ROWS
  always_comb begin
    asm_next = assembly;
    for (int c = 0; c < NO_COLS; c++) begin
      for (int r = 0; r < NO_ROWS; r++) begin
        if (CNT_W'(c * NO_ROWS + r) == byte_cnt) begin
          asm_next[r][c] = wr_byte;
        end
      end
    end
  end

  // Assembly register and byte counter, counter wraps after the last byte
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      assembly <= '0;
      byte_cnt <= '0;
    end else if (wr_en) begin
      assembly <= asm_next;
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  // The pushed block already includes the byte written on this edge
  aes_blk_fifo #(
    .BUF_SIZE (BUF_SIZE),
    .NO_ROWS  (NO_ROWS),
    .NO_COLS  (NO_COLS)
  ) u_blk_fifo (
    .aes_clk  (aes_clk),
    .resetn   (resetn),
    .push     (push),
    .push_blk (asm_next),
    .pop      (plain_txt_vld && plain_txt_rdy),
    .head_blk (plain_txt),
    .level    (buf_level)
  );

endmodule

`default_nettype wire

// File: tb/tb_aes_encryptor_ip_buffer.sv
// ============================================================================
// Module      : tb_aes_encryptor_ip_buffer
// Description : Self-checking bench for aes_encryptor_ip_buffer with a
//               byte/block queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_encryptor_ip_buffer;
  import aes_pkg::*;

  localparam int BUF_SIZE = 4;
  localparam int LVL_W    = $clog2(BUF_SIZE+1);

  logic             aes_clk = 1'b0;
  logic             resetn;
  logic [7:0]       in_byte;
  logic             in_byte_vld;
  logic             in_byte_rdy;
  logic             in_last;
  aes_state_t       plain_txt;
  logic             plain_txt_vld;
  logic             plain_txt_rdy;
  logic [LVL_W-1:0] buf_level;

  aes_encryptor_ip_buffer #(
    .BUF_SIZE (BUF_SIZE),
    .NO_ROWS  (4),
    .NO_COLS  (4)
  ) dut (
    .aes_clk       (aes_clk),
    .resetn        (resetn),
    .in_byte       (in_byte),
    .in_byte_vld   (in_byte_vld),
    .in_byte_rdy   (in_byte_rdy),
    .in_last       (in_last),
    .plain_txt     (plain_txt),
    .plain_txt_vld (plain_txt_vld),
    .plain_txt_rdy (plain_txt_rdy),
    .buf_level     (buf_level)
  );

  always #5 aes_clk = ~aes_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  aes_state_t m_q[$];
  aes_state_t m_blk;
  int         m_cnt;
  bit         m_up;
  bit         m_pad;
  bit         m_acc;
  int         n_popped;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_blk = '0;
    m_cnt = 0;
    m_up  = 0;
    m_pad = 0;
  endtask

  // One clock: check at the falling edge, advance model, return after rising edge
  task automatic tick();
    bit exp_rdy, do_pop, wr, push;
    @(negedge aes_clk);
    m_acc = 0;
    if (!resetn) begin
      chk("rst_in_byte_rdy", in_byte_rdy, 0);
      chk("rst_plain_txt_vld", plain_txt_vld, 0);
      chk("rst_buf_level", buf_level, 0);
      chk("rst_plain_txt", plain_txt, 0);
      model_reset();
    end else begin
      exp_rdy = m_up && !m_pad && !(m_cnt == 15 && m_q.size() == BUF_SIZE);
      chk("in_byte_rdy", in_byte_rdy, exp_rdy);
      chk("plain_txt_vld", plain_txt_vld, m_q.size() != 0);
      chk("buf_level", buf_level, m_q.size());
      if (m_q.size() != 0) chk("plain_txt", plain_txt, m_q[0]);
      m_acc  = in_byte_vld && exp_rdy;
      do_pop = (m_q.size() != 0) && plain_txt_rdy;
      wr     = 0;
      push   = 0;
      if (m_acc) begin
        m_blk[m_cnt % 4][m_cnt / 4] = in_byte;
        wr = 1;
`ifdef AES_IP_BUF_PAD_EN
        if (in_last && m_cnt != 15) m_pad = 1;
`endif
      end else if (m_pad && (m_cnt != 15 || m_q.size() < BUF_SIZE)) begin
        m_blk[m_cnt % 4][m_cnt / 4] = 8'h00;
        wr = 1;
        if (m_cnt == 15) m_pad = 0;
      end
      if (wr) begin
        if (m_cnt == 15) push = 1;
        m_cnt = (m_cnt + 1) % 16;
      end
      if (do_pop) begin
        void'(m_q.pop_front());
        n_popped++;
      end
      if (push) m_q.push_back(m_blk);
      m_up = 1;
    end
    @(posedge aes_clk);
    #1;
  endtask

  function automatic bit rnd_last();
`ifdef AES_IP_BUF_PAD_EN
    return 1'b0;
`else
    return 1'($urandom_range(0, 1));
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit last);
    int n;
    in_byte     = b;
    in_last     = last;
    in_byte_vld = 1'b1;
    m_acc       = 0;
    n           = 0;
    while (!m_acc && n < 200) begin
      tick();
      n++;
    end
    chk("send_accepted", m_acc, 1);
    in_byte_vld = 1'b0;
    in_last     = 1'b0;
  endtask

  task automatic send_block(input aes_state_t blk);
    for (int k = 0; k < 16; k++) send_byte(blk[k % 4][k / 4], rnd_last());
  endtask

  task automatic drain();
    int n;
    plain_txt_rdy = 1'b1;
    n = 0;
    while (m_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_level", buf_level, 0);
    plain_txt_rdy = 1'b0;
  endtask

  logic [7:0] vec [16] = '{8'h32, 8'h43, 8'hf6, 8'ha8, 8'h88, 8'h5a, 8'h30, 8'h8d,
                           8'h31, 8'h31, 8'h98, 8'ha2, 8'he0, 8'h37, 8'h07, 8'h34};

  initial begin
    aes_state_t blk;
    int base;
    resetn        = 1'b0;
    in_byte       = 8'h00;
    in_byte_vld   = 1'b1;
    in_last       = 1'b0;
    plain_txt_rdy = 1'b0;
    n_popped      = 0;
    model_reset();

    // Reset state, with upstream already offering data
    repeat (3) tick();
    in_byte_vld = 1'b0;
    resetn = 1'b1;
    tick();
    tick();
    chk("rdy_after_release", in_byte_rdy, 1);

    // Known vector, one block
    for (int k = 0; k < 16; k++) send_byte(vec[k], rnd_last());
    chk("vec_vld", plain_txt_vld, 1);
    chk("vec_r0c0", plain_txt[0][0], 8'h32);
    chk("vec_r1c0", plain_txt[1][0], 8'h43);
    chk("vec_r0c1", plain_txt[0][1], 8'h88);
    chk("vec_r3c3", plain_txt[3][3], 8'h34);
    chk("vec_level", buf_level, 1);
    drain();

    // Back-pressure: fill the FIFO, then 15 bytes; 16th must stall
    plain_txt_rdy = 1'b0;
    repeat (4 * 16 + 15) send_byte(8'($urandom_range(0, 255)), rnd_last());
    in_byte     = 8'ha5;
    in_byte_vld = 1'b1;
    repeat (3) tick();
    chk("bp_rdy_low", in_byte_rdy, 0);
    chk("bp_level_full", buf_level, 4);
    plain_txt_rdy = 1'b1;
    tick();
    plain_txt_rdy = 1'b0;
    send_byte(8'ha5, 1'b0);
    chk("bp_refill_level", buf_level, 4);
    drain();

    // Continuous streaming across pointer wrap
    plain_txt_rdy = 1'b1;
    base = n_popped;
    for (int k = 0; k < 160; k++) begin
      send_byte(8'($urandom_range(0, 255)), rnd_last());
      chk("stream_level_le1", buf_level <= 1, 1);
    end
    tick();
    tick();
    chk("stream_blocks", n_popped - base, 10);
    plain_txt_rdy = 1'b0;

    // Reset with a partial block and two queued blocks
    repeat (2 * 16 + 7) send_byte(8'($urandom_range(0, 255)), rnd_last());
    chk("pre_rst_level", buf_level, 2);
    resetn = 1'b0;
    tick();
    chk("mid_rst_vld", plain_txt_vld, 0);
    chk("mid_rst_level", buf_level, 0);
    resetn = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 16; k++) blk[k % 4][k / 4] = 8'($urandom_range(0, 255));
    send_block(blk);
    chk("fresh_vld", plain_txt_vld, 1);
    chk("fresh_block", plain_txt, blk);
    chk("fresh_level", buf_level, 1);
    drain();

`ifdef AES_IP_BUF_PAD_EN
    // Short message padded with zeros
    plain_txt_rdy = 1'b0;
    for (int k = 1; k <= 5; k++) send_byte(8'(k), k == 5);
    repeat (10) tick();
    chk("pad_vld_early", plain_txt_vld, 0);
    tick();
    chk("pad_vld", plain_txt_vld, 1);
    blk = '0;
    blk[0][0] = 8'h01;
    blk[1][0] = 8'h02;
    blk[2][0] = 8'h03;
    blk[3][0] = 8'h04;
    blk[0][1] = 8'h05;
    chk("pad_block", plain_txt, blk);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
